// File: rtl/sram_access_fsm.sv
// Single-port sequencer for an external asynchronous 16-bit SRAM: IDLE->SETUP->ACCESS->HOLD.
// Latency: req accept to ack is 2+WAIT_CYCLES cycles; one access per 3+WAIT_CYCLES cycles.
// Backpressure: ready is low outside IDLE, while enable is low, or in reset; req is not queued.
// Optional macro SRAM_BYTE_LANE_EN adds the be[1:0] byte-lane input driving ub_n/lb_n.
module sram_access_fsm #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_BYTE_LANE_EN
  input  logic [1:0]        be,
`endif
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Counter is loaded so that ACCESS lasts exactly WAIT_CYCLES cycles (counts down to 0).
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_ub_n;
  logic              r_lb_n;
  logic              w_ready;
  logic              w_accept;
  logic              w_ub_n_sel;
  logic              w_lb_n_sel;

  assign w_ready  = (r_state == ST_IDLE) && enable && !reset;
  assign w_accept = req && w_ready;

`ifdef SRAM_BYTE_LANE_EN
  assign w_ub_n_sel = ~be[1];
  assign w_lb_n_sel = ~be[0];
`else
  // Full-word accesses only: both lanes strobed for every access.
  assign w_ub_n_sel = 1'b0;
  assign w_lb_n_sel = 1'b0;
`endif

  // State register; reset aborts any access and returns to IDLE.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; enable is only consulted in IDLE so a started access always completes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (r_cnt == 4'd0) w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered SRAM pins, request capture, wait counter, ack and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            // The address/data registers double as the pin drivers for SETUP..HOLD.
            r_we        <= we;
            r_sram_addr <= addr;
            if (we) r_dq_out <= wdata;
            r_ce_n      <= 1'b0;
            r_oe_n      <= we;
            r_we_n      <= 1'b1;
            r_dq_oe     <= we;
            r_ub_n      <= w_ub_n_sel;
            r_lb_n      <= w_lb_n_sel;
          end
        end
        ST_SETUP: begin
          r_cnt  <= CNT_LOAD;
          r_we_n <= ~r_we;
        end
        ST_ACCESS: begin
          if (r_cnt == 4'd0) begin
            // Strobes release while address and write data stay driven through HOLD.
            r_we_n <= 1'b1;
            r_oe_n <= 1'b1;
            r_ack  <= 1'b1;
            if (!r_we) r_rdata <= sram_dq_in;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_ub_n  <= 1'b1;
          r_lb_n  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready       = w_ready;
  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_ub_n   = r_ub_n;
  assign sram_lb_n   = r_lb_n;

endmodule

// File: tb/tb_sram_access_fsm.sv
// Directed bench for sram_access_fsm with a small behavioural SRAM model.
// Strobe vector layout: {ce_n, oe_n, we_n, ub_n, lb_n, dq_oe}.
module tb_sram_access_fsm;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        req;
  logic        we;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic        ready;
  logic        ack;
  logic [15:0] rdata;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
`ifdef SRAM_BYTE_LANE_EN
  logic [1:0]  be;
  localparam logic [1:0] LN = 2'b01;  // be=2'b10: ub_n=0, lb_n=1
`else
  localparam logic [1:0] LN = 2'b00;  // both lanes always strobed
`endif

  localparam logic [5:0] S_IDLE  = 6'b111110;
  localparam logic [5:0] WR_SET  = {1'b0, 1'b1, 1'b1, LN, 1'b1};
  localparam logic [5:0] WR_ACC  = {1'b0, 1'b1, 1'b0, LN, 1'b1};
  localparam logic [5:0] WR_HOLD = {1'b0, 1'b1, 1'b1, LN, 1'b1};
  localparam logic [5:0] RD_SET  = {1'b0, 1'b0, 1'b1, LN, 1'b0};
  localparam logic [5:0] RD_ACC  = {1'b0, 1'b0, 1'b1, LN, 1'b0};
  localparam logic [5:0] RD_HOLD = {1'b0, 1'b1, 1'b1, LN, 1'b0};

  int n_checks;
  int n_fail;
  logic [15:0] mem [0:4095];
  logic [5:0]  strb;

  assign strb       = {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe};
  assign sram_dq_in = mem[sram_addr[11:0]];

  sram_access_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
`ifdef SRAM_BYTE_LANE_EN
    .be          (be),
`endif
    .ready       (ready),
    .ack         (ack),
    .rdata       (rdata),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: a write lands while ce_n and we_n are both low and data is driven.
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr[11:0]] <= sram_dq_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete access from IDLE with WAIT_CYCLES=2, checking every phase.
  task automatic do_access(input logic w, input logic [19:0] a, input logic [15:0] d,
                           input logic [15:0] exp_rd, input string tag);
    tick();
    enable = 1'b1; we = w; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    tick();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    @(negedge clk);
    check({tag, "_setup_strb"}, 32'(strb), 32'(w ? WR_SET : RD_SET));
    check({tag, "_setup_addr"}, 32'(sram_addr), 32'(a));
    check({tag, "_setup_ack"}, 32'(ack), 32'd0);
    if (w) check({tag, "_setup_dq"}, 32'(sram_dq_out), 32'(d));
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      check({tag, "_acc_strb"}, 32'(strb), 32'(w ? WR_ACC : RD_ACC));
      check({tag, "_acc_ack"}, 32'(ack), 32'd0);
    end
    tick();
    @(negedge clk);
    check({tag, "_hold_strb"}, 32'(strb), 32'(w ? WR_HOLD : RD_HOLD));
    check({tag, "_hold_ack"}, 32'(ack), 32'd1);
    check({tag, "_hold_addr"}, 32'(sram_addr), 32'(a));
    check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
    tick();
    @(negedge clk);
    check({tag, "_idle_strb"}, 32'(strb), 32'(S_IDLE));
    check({tag, "_idle_ack"}, 32'(ack), 32'd0);
    check({tag, "_idle_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    reset = 1'b1; enable = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
`ifdef SRAM_BYTE_LANE_EN
    be = 2'b10;
`endif
    tick();
    tick();
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_dq_out", 32'(sram_dq_out), 32'd0);
    check("rst_strb", 32'(strb), 32'(S_IDLE));

    // Disabled: requests ignored for 10 cycles.
    tick();
    reset = 1'b0; enable = 1'b0; req = 1'b1; we = 1'b1; addr = 20'h00ABC; wdata = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("dis_rdy_ack_strb", 32'({ready, ack, strb}), 32'({1'b0, 1'b0, S_IDLE}));
      tick();
    end
    req = 1'b0;
    check("dis_mem", 32'(mem[12'hABC]), 32'd0);

    // enable and req rise together: accepted that cycle.
    do_access(1'b1, 20'h00ABC, 16'h5A5A, 16'h0000, "wr1");
    check("wr1_mem", 32'(mem[12'hABC]), 32'h5A5A);
    do_access(1'b0, 20'h00ABC, 16'h0000, 16'h5A5A, "rd1");
    do_access(1'b1, 20'h00001, 16'h1234, 16'h5A5A, "wr2");
    do_access(1'b0, 20'h00001, 16'h0000, 16'h1234, "rd2");

    // enable dropped in the first ACCESS cycle of a write.
    tick();
    we = 1'b1; addr = 20'h00F00; wdata = 16'hC3C3; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    enable = 1'b0;
    @(negedge clk);
    check("endrop_acc1_strb", 32'(strb), 32'(WR_ACC));
    check("endrop_ready", 32'(ready), 32'd0);
    tick();
    @(negedge clk);
    check("endrop_acc2_strb", 32'(strb), 32'(WR_ACC));
    tick();
    @(negedge clk);
    check("endrop_hold_ack", 32'(ack), 32'd1);
    check("endrop_hold_strb", 32'(strb), 32'(WR_HOLD));
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("endrop_after", 32'({ready, ack, strb}), 32'({1'b0, 1'b0, S_IDLE}));
    end
    req = 1'b0;
    check("endrop_mem", 32'(mem[12'hF00]), 32'hC3C3);

    // Reset during the second ACCESS cycle of a write: aborted, no ack.
    tick();
    enable = 1'b1; we = 1'b1; addr = 20'h00F0F; wdata = 16'h0FF0; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_acc2_strb", 32'(strb), 32'(WR_ACC));
    check("rstmid_ready", 32'(ready), 32'd0);
    tick();
    @(negedge clk);
    check("rstmid_strb", 32'(strb), 32'(S_IDLE));
    check("rstmid_ack", 32'(ack), 32'd0);
    check("rstmid_addr", 32'(sram_addr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("rstmid_after", 32'({ready, ack, strb}), 32'({1'b1, 1'b0, S_IDLE}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
